// File: rtl/jt12_opsched_pkg.sv
// Shared constants and types for the FM operator slot scheduler.
// Stage codes follow the slot order, so slot/6 maps directly onto them.
package jt12_opsched_pkg;

  typedef enum logic [1:0] {
    STG_S1 = 2'd0,
    STG_S3 = 2'd1,
    STG_S2 = 2'd2,
    STG_S4 = 2'd3
  } stage_e;

  localparam int SLOT_COUNT = 24;
  localparam int CH_COUNT   = 6;

  typedef struct packed {
    logic       s1;
    logic       s2;
    logic       s3;
    logic       s4;
    logic [2:0] cur_ch;
    logic [2:0] cur_alg;
    logic       prevprev1;
    logic       prev2;
    logic       internal_x;
    logic       internal_y;
    logic       prev1;
    logic       zero;
  } out_t;

  function automatic stage_e slot_stage(input logic [4:0] slot);
    if (slot < 5'(CH_COUNT))          return STG_S1;
    else if (slot < 5'(2 * CH_COUNT)) return STG_S3;
    else if (slot < 5'(3 * CH_COUNT)) return STG_S2;
    else                              return STG_S4;
  endfunction

  function automatic logic [2:0] slot_chan(input logic [4:0] slot);
    logic [4:0] base;
    if (slot < 5'(CH_COUNT))          base = 5'd0;
    else if (slot < 5'(2 * CH_COUNT)) base = 5'(CH_COUNT);
    else if (slot < 5'(3 * CH_COUNT)) base = 5'(2 * CH_COUNT);
    else                              base = 5'(3 * CH_COUNT);
    return 3'(slot - base);
  endfunction

endpackage

// File: rtl/jt12_opsched_if.sv
// Algorithm register write bus shared by the scheduler and its alg storage.
interface jt12_opsched_if;
  logic       alg_we;
  logic [2:0] alg_ch;
  logic [2:0] alg_din;

  modport master (output alg_we, alg_ch, alg_din);
  modport slave  (input  alg_we, alg_ch, alg_din);
endinterface

// File: rtl/jt12_opsched_algrf.sv
// Pending/active algorithm storage; active is refreshed on each S1 issue so
// a channel keeps one algorithm across all four operators of a sample.
module jt12_opsched_algrf
  import jt12_opsched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue,
  input  logic                 is_s1,
  input  logic [2:0]           slot_ch,
  jt12_opsched_if.slave        alg_wr,
  output logic [2:0]           alg_sel
);

  logic [CH_COUNT-1:0][2:0] pending_q, pending_d;
  logic [CH_COUNT-1:0][2:0] active_q, active_d;
  logic                     wr_valid;

  // Reading pending_d on S1 gives the same-cycle write bypass for free.
  always_comb begin
    pending_d = pending_q;
    active_d  = active_q;
    wr_valid  = alg_wr.alg_we && (alg_wr.alg_ch < 3'(CH_COUNT));
    if (wr_valid) pending_d[alg_wr.alg_ch] = alg_wr.alg_din;
    alg_sel = is_s1 ? pending_d[slot_ch] : active_q[slot_ch];
    if (issue && is_s1) active_d[slot_ch] = pending_d[slot_ch];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      active_q  <= '0;
    end else begin
      pending_q <= pending_d;
      active_q  <= active_d;
    end
  end

endmodule

// File: rtl/jt12_opsched.sv
// Operator slot scheduler: 24-slot counter, per-slot stage/channel decode and
// modulator-source selects, registered one cycle after the counter value.
module jt12_opsched
  import jt12_opsched_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  jt12_opsched_if.slave alg_wr,
  output logic          s1_enters,
  output logic          s2_enters,
  output logic          s3_enters,
  output logic          s4_enters,
  output logic [2:0]    cur_ch,
  output logic [2:0]    cur_alg,
  output logic          use_prevprev1,
  output logic          use_prev2,
  output logic          use_internal_x,
  output logic          use_internal_y,
  output logic          use_prev1,
  output logic          zero
);

  logic [4:0] slot_q, slot_d;
  out_t       out_q, out_d;
  stage_e     stage;
  logic [2:0] slot_ch;
  logic [2:0] alg_sel;

  function automatic out_t slot_decode(input stage_e stg, input logic [2:0] ch,
                                       input logic [2:0] a, input logic first);
    out_t o;
    logic s1, s2, s3, s4;
    s1 = (stg == STG_S1);
    s2 = (stg == STG_S2);
    s3 = (stg == STG_S3);
    s4 = (stg == STG_S4);
    o.s1         = s1;
    o.s2         = s2;
    o.s3         = s3;
    o.s4         = s4;
    o.cur_ch     = ch;
    o.cur_alg    = a;
    o.prevprev1  = s1 | (s3 & (a == 3'd5));
    o.prev2      = (s3 & (a <= 3'd2)) | (s4 & (a == 3'd3));
    o.internal_x = s4 & (a == 3'd2);
    o.internal_y = s4 & (a inside {3'd0, 3'd1, 3'd3, 3'd4});
    o.prev1      = s1 | (s3 & (a == 3'd1))
                 | (s2 & (a inside {3'd0, 3'd3, 3'd4, 3'd5, 3'd6}))
                 | (s4 & (a inside {3'd2, 3'd5}));
    o.zero       = first;
    return o;
  endfunction

  jt12_opsched_algrf u_algrf (
    .clk     (clk),
    .rst     (rst),
    .issue   (clk_en),
    .is_s1   (stage == STG_S1),
    .slot_ch (slot_ch),
    .alg_wr  (alg_wr),
    .alg_sel (alg_sel)
  );

  always_comb begin
    stage   = slot_stage(slot_q);
    slot_ch = slot_chan(slot_q);
    slot_d  = slot_q;
    out_d   = out_q;
    if (clk_en) begin
      slot_d = (slot_q == 5'(SLOT_COUNT - 1)) ? 5'd0 : slot_q + 5'd1;
      out_d  = slot_decode(stage, slot_ch, alg_sel, slot_q == 5'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      out_q  <= '0;
    end else begin
      slot_q <= slot_d;
      out_q  <= out_d;
    end
  end

  assign s1_enters      = out_q.s1;
  assign s2_enters      = out_q.s2;
  assign s3_enters      = out_q.s3;
  assign s4_enters      = out_q.s4;
  assign cur_ch         = out_q.cur_ch;
  assign cur_alg        = out_q.cur_alg;
  assign use_prevprev1  = out_q.prevprev1;
  assign use_prev2      = out_q.prev2;
  assign use_internal_x = out_q.internal_x;
  assign use_internal_y = out_q.internal_y;
  assign use_prev1      = out_q.prev1;
  assign zero           = out_q.zero;

endmodule

// File: doc/jt12_opsched.md
JT12_OPSCHED -- requirements
Module: jt12_opsched

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; ports named as below.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 clk_en  input  1  slot-advance enable; no state changes (except alg writes, REQ-021) when low.
REQ-005 alg_we  input  1  algorithm write strobe, one-cycle pulse.
REQ-006 alg_ch  input  3  channel index of write, valid 0..5.
REQ-007 alg_din  input  3  algorithm value 0..7.
REQ-008 s1_enters, s2_enters, s3_enters, s4_enters  output  1 each  one-hot operator-stage flags, registered.
REQ-009 cur_ch  output  3  channel of current slot, registered.
REQ-010 cur_alg  output  3  latched algorithm of current channel, registered.
REQ-011 use_prevprev1, use_prev2, use_internal_x, use_internal_y, use_prev1  output  1 each  modulator-source selects, registered.
REQ-012 zero  output  1  high for the slot-0 presentation (S1, ch 0).

Function
REQ-013 Internal slot counter 0..23 SHALL advance by 1 on each clk, clk_en=1 edge; wrap 23->0.
REQ-014 Stage = slot/6 mapped 0:S1, 1:S3, 2:S2, 3:S4; channel = slot mod 6.
REQ-015 On each clk_en edge, outputs SHALL be loaded from the counter value before increment (1-cycle latency: counter=k -> outputs show slot k next cycle).
REQ-016 Exactly one sN_enters SHALL be high whenever outputs are valid; zero=1 only when presenting slot 0.
REQ-017 Two alg arrays of 6x3 bits: pending (written by port), active (used for decode).
REQ-018 When issuing an S1 slot for channel c, active[c] SHALL be loaded from pending[c] and that value SHALL drive cur_alg and decode for that slot; S3/S2/S4 slots use active[c] unchanged, so a channel's algorithm is constant across S1..S4 of one sample.
REQ-019 Decode (a = algorithm used for the slot): use_prevprev1 = S1 | S3&(a=5); use_prev2 = S3&(a<=2) | S4&(a=3); use_internal_x = S4&(a=2); use_internal_y = S4&(a in {0,1,3,4}); use_prev1 = S1 | S3&(a=1) | S2&(a in {0,3,4,5,6}) | S4&(a in {2,5}).
REQ-020 Write with alg_ch in 6..7 SHALL be ignored.
REQ-021 alg writes SHALL take effect regardless of clk_en.
REQ-022 Write to pending[c] coinciding with issue of S1 for c SHALL bypass: the written value is latched into active[c] and used that slot.
REQ-023 Write coinciding with S3/S2/S4 of c SHALL not alter current sample; it applies from next S1 of c.
REQ-024 With clk_en=0, all outputs SHALL hold their values.

Reset
REQ-025 On rst=1: slot counter=0, all sN_enters=0, all use_*=0, zero=0, cur_ch=0, cur_alg=0, pending and active arrays=0.
REQ-026 rst SHALL override clk_en and alg_we in the same cycle; reset mid-sample discards partial sample.
REQ-027 First clk_en edge after reset SHALL present slot 0 (s1_enters=1, cur_ch=0, zero=1).

Structure
REQ-028 Stage encoding constants (S1,S3,S2,S4 order), slot count 24, channel count 6 SHALL live in the shared jt12 package.
REQ-029 The pending/active alg storage with S1 transfer and bypass SHALL be one sub-module, jt12_opsched_algrf; counter and decode remain in the top.

Verification
REQ-030 Reset, then 24 clk_en pulses, all alg=0 -> sequence S1 ch0..5, S3 ch0..5, S2 ch0..5, S4 ch0..5; zero only on first; use_prev1=1 on S1 and S2 slots, use_internal_y=1 on S4 slots.
REQ-031 Write alg_ch=2, alg_din=5 during S3 of ch2 -> S2/S4 of ch2 still use alg 0; next S1 of ch2 shows cur_alg=5, then S3 ch2 use_prevprev1=1, S4 ch2 use_prev1=1.
REQ-032 Write alg_ch=0, alg_din=2 coincident with S1-ch0 issue -> that slot cur_alg=2; S4 ch0 use_internal_x=1, use_prev1=1.
REQ-033 Write alg_ch=7 -> no array change; all 6 channels unchanged over 48 slots.
REQ-034 clk_en held low 10 cycles mid-sample -> outputs frozen; resumes next slot; rst asserted at slot 13 -> all outputs 0, next clk_en presents slot 0.
REQ-035 Sweep alg 0..7 on ch5 -> each use_* flag matches REQ-019 table for all four stages.
